// File: rtl/led_status_pwm.sv
`default_nettype none
// ============================================================================
// Module   : led_status_pwm
// Purpose  : Multi-channel status-LED driver. Each channel runs in one of four
//            modes: OFF, ON, BLINK or BREATHE. All channels share one
//            free-running PWM counter and one tick prescaler. Channel settings
//            are written one channel at a time over a valid/ready interface.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CHANNELS       number of LED channels (1..8)
//   PWM_BITS       PWM resolution and brightness level width
//   TICK_DIV       clk cycles per tick (>= 2)
//   RESET_ON_MASK  channels that come out of reset ON at full level
// Ports
//   clk_48mhz   in   system clock
//   reset_n     in   asynchronous active-low reset
//   cfg_valid   in   config request
//   cfg_ready   out  config can be accepted (1 from the first edge after reset)
//   cfg_chan    in   [2:0] target channel
//   cfg_mode    in   [1:0] 00 OFF, 01 ON, 10 BLINK, 11 BREATHE
//   cfg_level   in   [PWM_BITS-1:0] peak brightness
//   cfg_period  in   [7:0] BLINK half-period / BREATHE step, in ticks
//   cfg_err     out  1-cycle pulse when a request names a channel that does
//                    not exist
//   led_out     out  [CHANNELS-1:0] registered PWM outputs, active high
// Build option
//   LED_GAMMA_EN  adds a registered square-law brightness stage
//                 (one extra cycle of latency)
// ============================================================================
module led_status_pwm #(
   parameter int                  CHANNELS      = 3,
   parameter int                  PWM_BITS      = 8,
   parameter int                  TICK_DIV      = 48000,
   parameter logic [CHANNELS-1:0] RESET_ON_MASK = '0
) (
   input  logic                clk_48mhz,
   input  logic                reset_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [2:0]          cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_level,
   input  logic [7:0]          cfg_period,
   output logic                cfg_err,
   output logic [CHANNELS-1:0] led_out
);

   localparam int               PRE_W   = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_t;

   logic [PRE_W-1:0]    prescaler;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                chan_ok;
   logic                xfer;
   logic [CHANNELS-1:0] led_next;

   assign tick    = (prescaler == PRE_MAX);
   assign chan_ok = ({1'b0, cfg_chan} < 4'(CHANNELS));
   assign xfer    = cfg_valid && cfg_ready;

   // Shared timebase: tick prescaler and free-running PWM counter.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
         pwm_cnt   <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PRE_W'(1);
         pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Handshake: ready is held low only during reset; a request to a missing
   // channel is dropped and flagged on the following cycle.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_ready <= 1'b1;
         cfg_err   <= xfer && !chan_ok;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      mode_t               mode;
      logic [PWM_BITS-1:0] level;
      logic [PWM_BITS-1:0] ramp;
      logic [PWM_BITS-1:0] duty;
      logic [PWM_BITS-1:0] duty_next;
      logic [PWM_BITS-1:0] duty_eff;
      logic [7:0]          period;
      logic [7:0]          tick_cnt;
      logic                phase;
      logic                dir_down;
      logic                sel;
      logic                period_hit;

      assign sel        = xfer && chan_ok && (cfg_chan == 3'(i));
      assign period_hit = ((tick_cnt + 8'd1) == period);

      always_comb begin
         duty_next = '0;
         case (mode)
            MODE_ON:      duty_next = level;
            MODE_BLINK:   duty_next = phase ? level : '0;
            MODE_BREATHE: duty_next = ramp;
            default:      duty_next = '0;
         endcase
      end

      // A config write takes priority over a tick on the same edge, so the
      // restarted channel simply misses that tick.
      always_ff @(posedge clk_48mhz or negedge reset_n) begin
         if (!reset_n) begin
            mode     <= RESET_ON_MASK[i] ? MODE_ON : MODE_OFF;
            level    <= {PWM_BITS{RESET_ON_MASK[i]}};
            period   <= 8'd1;
            tick_cnt <= '0;
            phase    <= 1'b1;
            ramp     <= '0;
            dir_down <= 1'b0;
            duty     <= '0;
         end else begin
            duty <= duty_next;
            if (sel) begin
               mode     <= mode_t'(cfg_mode);
               level    <= cfg_level;
               period   <= (cfg_period == 8'd0) ? 8'd1 : cfg_period;
               tick_cnt <= '0;
               phase    <= 1'b1;
               ramp     <= '0;
               dir_down <= 1'b0;
            end else if (tick && (mode == MODE_BLINK || mode == MODE_BREATHE)) begin
               if (period_hit) begin
                  tick_cnt <= '0;
                  if (mode == MODE_BLINK) begin
                     phase <= !phase;
                  end else if (!dir_down) begin
                     // Ramp stops at level; level 0 keeps the ramp at 0.
                     if (ramp < level) begin
                        ramp <= ramp + PWM_BITS'(1);
                        if ((ramp + PWM_BITS'(1)) == level)
                           dir_down <= 1'b1;
                     end
                  end else begin
                     if (ramp != '0) begin
                        ramp <= ramp - PWM_BITS'(1);
                        if (ramp == PWM_BITS'(1))
                           dir_down <= 1'b0;
                     end
                  end
               end else begin
                  tick_cnt <= tick_cnt + 8'd1;
               end
            end
         end
      end

`ifdef LED_GAMMA_EN
      logic [2*PWM_BITS-1:0] duty_sq;
      assign duty_sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};

      // Full scale is pinned to full scale so ON/255 stays at maximum.
      always_ff @(posedge clk_48mhz or negedge reset_n) begin
         if (!reset_n)
            duty_eff <= '0;
         else if (duty == '1)
            duty_eff <= '1;
         else
            duty_eff <= duty_sq[2*PWM_BITS-1:PWM_BITS];
      end
`else
      assign duty_eff = duty;
`endif

      assign led_next[i] = (pwm_cnt < duty_eff);
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n)
         led_out <= '0;
      else
         led_out <= led_next;
   end

endmodule
`default_nettype wire
